// File: rtl/dco_tune_ctrl.sv
// DCO acquisition/tracking controller: SAR coarse search on the ring-oscillator
// select, then bias + signed loop-filter code with clamp, lock detect and re-acquire.
module dco_tune_ctrl #(
  parameter int unsigned RO_WIDTH      = 8,
  parameter int unsigned DCO_CC_WIDTH  = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned LOCK_THRESH   = 2,
  parameter int unsigned SAT_LIMIT     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    pd_valid_i,
  input  logic                    pd_fast_i,
  input  logic [DCO_CC_WIDTH-1:0] dco_cc_i,
  input  logic                    dco_cc_valid_i,
  output logic [RO_WIDTH-1:0]     f_sel_o,
  output logic                    f_sel_upd_o,
  output logic [RO_WIDTH-1:0]     bias_o,
  output logic [1:0]              state_o,
  output logic                    locked_o,
  output logic                    sat_o,
  output logic                    busy_o
);

  localparam int unsigned SW  = RO_WIDTH + 2;
  localparam int unsigned CW  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned LW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned SLW = (SAT_LIMIT > 1) ? $clog2(SAT_LIMIT) : 1;
  localparam int unsigned IW  = (RO_WIDTH > 1) ? $clog2(RO_WIDTH) : 1;
  localparam logic [RO_WIDTH-1:0] MID = {1'b1, {(RO_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    TRACK   = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic [RO_WIDTH-1:0]   r_fsel, w_fsel;
  logic [RO_WIDTH-1:0]   r_bias, w_bias;
  logic                  r_upd, w_upd;
  logic                  r_locked, w_locked;
  logic                  r_sat, w_sat;
  logic [IW-1:0]         r_idx, w_idx;
  logic [CW-1:0]         r_settle_cnt, w_settle_cnt;
  logic [LW-1:0]         r_lock_cnt, w_lock_cnt;
  logic [SLW-1:0]        r_sat_cnt, w_sat_cnt;
  logic                  w_reacq;

  logic [SW-1:0]           w_sum;
  logic [RO_WIDTH-1:0]     w_clamped;
  logic                    w_clamp_hit;
  logic [DCO_CC_WIDTH:0]   w_cc_wide, w_cc_abs;
  logic                    w_in_thresh;
  logic [RO_WIDTH-1:0]     w_trial_bit, w_code;

  assign w_sum = {2'b00, r_bias}
               + {{(SW-DCO_CC_WIDTH){dco_cc_i[DCO_CC_WIDTH-1]}}, dco_cc_i};

  always_comb begin
    w_clamped   = w_sum[RO_WIDTH-1:0];
    w_clamp_hit = 1'b0;
    if (w_sum[SW-1]) begin
      w_clamped   = '0;
      w_clamp_hit = 1'b1;
    end else if (w_sum[SW-2]) begin
      w_clamped   = '1;
      w_clamp_hit = 1'b1;
    end
  end

  // Magnitude taken one bit wider so the most negative code does not wrap.
  assign w_cc_wide   = {dco_cc_i[DCO_CC_WIDTH-1], dco_cc_i};
  assign w_cc_abs    = w_cc_wide[DCO_CC_WIDTH] ? (~w_cc_wide + (DCO_CC_WIDTH+1)'(1)) : w_cc_wide;
  assign w_in_thresh = (w_cc_abs <= (DCO_CC_WIDTH+1)'(LOCK_THRESH));

  assign w_trial_bit = RO_WIDTH'(1) << r_idx;
  assign w_code      = pd_fast_i ? (r_fsel & ~w_trial_bit) : r_fsel;

  always_comb begin
    w_state      = r_state;
    w_fsel       = r_fsel;
    w_bias       = r_bias;
    w_upd        = 1'b0;
    w_locked     = r_locked;
    w_sat        = r_sat;
    w_idx        = r_idx;
    w_settle_cnt = r_settle_cnt;
    w_lock_cnt   = r_lock_cnt;
    w_sat_cnt    = r_sat_cnt;
    w_reacq      = 1'b0;

    case (r_state)
      IDLE: ;
      // The first SETTLE cycle doubles as the trial write cycle.
      SETTLE: begin
        if (r_settle_cnt == CW'(SETTLE_CYCLES)) begin
          w_state      = MEASURE;
          w_settle_cnt = '0;
        end else begin
          w_settle_cnt = r_settle_cnt + 1'b1;
        end
      end
      MEASURE: begin
        if (pd_valid_i) begin
          w_upd = 1'b1;
          if (r_idx != '0) begin
            w_fsel  = w_code | (w_trial_bit >> 1);
            w_idx   = r_idx - 1'b1;
            w_state = SETTLE;
          end else begin
            w_fsel  = w_code;
            w_bias  = w_code;
            w_state = TRACK;
          end
        end
      end
      TRACK: begin
        if (dco_cc_valid_i) begin
          w_fsel = w_clamped;
          w_upd  = 1'b1;
          w_sat  = w_clamp_hit;
          if (w_in_thresh) begin
            w_lock_cnt = (r_lock_cnt == LW'(LOCK_COUNT)) ? r_lock_cnt : r_lock_cnt + 1'b1;
            w_locked   = (w_lock_cnt == LW'(LOCK_COUNT));
          end else begin
            w_lock_cnt = '0;
            w_locked   = 1'b0;
          end
          if (!w_clamp_hit) begin
            w_sat_cnt = '0;
          end else if (r_sat_cnt == SLW'(SAT_LIMIT - 1)) begin
            w_reacq = 1'b1;
          end else begin
            w_sat_cnt = r_sat_cnt + 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase

    if (start_i || w_reacq) begin
      w_state      = SETTLE;
      w_fsel       = MID;
      w_upd        = 1'b1;
      w_idx        = IW'(RO_WIDTH - 1);
      w_settle_cnt = '0;
      w_locked     = 1'b0;
      w_sat        = 1'b0;
      w_lock_cnt   = '0;
      w_sat_cnt    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_fsel       <= MID;
      r_bias       <= MID;
      r_upd        <= 1'b0;
      r_locked     <= 1'b0;
      r_sat        <= 1'b0;
      r_idx        <= '0;
      r_settle_cnt <= '0;
      r_lock_cnt   <= '0;
      r_sat_cnt    <= '0;
    end else begin
      r_state      <= w_state;
      r_fsel       <= w_fsel;
      r_bias       <= w_bias;
      r_upd        <= w_upd;
      r_locked     <= w_locked;
      r_sat        <= w_sat;
      r_idx        <= w_idx;
      r_settle_cnt <= w_settle_cnt;
      r_lock_cnt   <= w_lock_cnt;
      r_sat_cnt    <= w_sat_cnt;
    end
  end

  assign f_sel_o     = r_fsel;
  assign f_sel_upd_o = r_upd;
  assign bias_o      = r_bias;
  assign state_o     = r_state;
  assign locked_o    = r_locked;
  assign sat_o       = r_sat;
  assign busy_o      = (r_state == SETTLE) || (r_state == MEASURE);

endmodule

// File: doc/dco_tune_ctrl.md
# dco_tune_ctrl

Acquisition and tracking controller for the ADPLL ring-oscillator DCO. It runs a successive-approximation (SAR) coarse search on the ring-oscillator frequency select, using the frequency detector's fast/slow decision, and captures the result as the DCO bias. It then tracks by applying the signed loop-filter control code on top of that bias, with saturation, lock detection and automatic re-acquisition. It sits between the loop filter / frequency detector and the ring oscillator `f_sel` input.

## Interface
- `RO_WIDTH`, 8: ring-oscillator select width; larger `f_sel` means higher DCO frequency.
- `DCO_CC_WIDTH`, 8: signed loop-filter control code width, `DCO_CC_WIDTH <= RO_WIDTH`.
- `SETTLE_CYCLES`, 16: clocks to wait after each coarse trial write, ≥1.
- `LOCK_COUNT`, 8: consecutive in-threshold updates required to assert lock.
- `LOCK_THRESH`, 2: lock window; an update is in-threshold if `|dco_cc_i| <= LOCK_THRESH`.
- `SAT_LIMIT`, 16: consecutive saturated updates that trigger re-acquisition.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `start_i`, in, 1: pulse that starts or restarts coarse acquisition.
- `pd_valid_i`, in, 1: frequency-detector decision strobe.
- `pd_fast_i`, in, 1: DCO faster than reference; sampled only with `pd_valid_i`.
- `dco_cc_i`, in, `DCO_CC_WIDTH`, signed: loop-filter control code.
- `dco_cc_valid_i`, in, 1: control-code strobe.
- `f_sel_o`, out, `RO_WIDTH`: registered ring-oscillator select.
- `f_sel_upd_o`, out, 1: one-cycle pulse when `f_sel_o` changes value or is rewritten.
- `bias_o`, out, `RO_WIDTH`: captured coarse result.
- `state_o`, out, 2: IDLE=0, SETTLE=1, MEASURE=2, TRACK=3.
- `locked_o`, out, 1: lock indicator.
- `sat_o`, out, 1: last tracking update was clamped.
- `busy_o`, out, 1: high in SETTLE or MEASURE.

## Operation
- **Reset** (overrides everything):
  - state IDLE; `f_sel_o` = `bias_o` = midscale (`1 << (RO_WIDTH-1)`).
  - `locked_o`, `sat_o`, `busy_o`, `f_sel_upd_o` all 0; all counters cleared.
- **IDLE**
  - Outputs hold.
  - `start_i` → load trial `1 << (RO_WIDTH-1)` into `f_sel_o`, pulse `f_sel_upd_o`, bit index = `RO_WIDTH-1`, go to SETTLE.
- **SETTLE**
  - Counts `SETTLE_CYCLES` clocks, then goes to MEASURE.
  - `pd_valid_i` is ignored here.
- **MEASURE**
  - Waits for the first `pd_valid_i`.
  - If `pd_fast_i`, clear the current trial bit; otherwise keep it.
  - If the bit index > 0: set the next lower bit, write `f_sel_o`, pulse upd, go to SETTLE.
  - If the bit index = 0: `bias_o` = final code, `f_sel_o` = final code (upd pulse), go to TRACK.
  - Result is the largest code for which the DCO is not fast.
- **TRACK**, on `dco_cc_valid_i`:
  - Interim sum = zero-extended bias + sign-extended `dco_cc_i`, both at `RO_WIDTH+2` bits.
  - Clamp the sum to `[0, 2^RO_WIDTH-1]` and register it into `f_sel_o`; upd pulses every update.
  - `sat_o` = clamp occurred on that update.
  - Lock counter: increments if in-threshold, saturating at `LOCK_COUNT`; otherwise cleared and `locked_o` drops.
  - `locked_o` = 1 when the counter reaches `LOCK_COUNT`.
  - Saturated-run counter: reaching `SAT_LIMIT` clears `locked_o` and starts coarse acquisition as if `start_i` had been seen.
  - `dco_cc_valid_i` is ignored outside TRACK.
- **`start_i` in any non-IDLE state**
  - Aborts the current activity; coarse acquisition restarts the next cycle.
  - Clears `locked_o`, `sat_o` and the counters.
  - `bias_o` holds its old value until the new search completes.
- **Simultaneous events:** `rst_i` > `start_i` > `dco_cc_valid_i` / `pd_valid_i`.

## Timing
- `f_sel_o`, `f_sel_upd_o`, `sat_o` and `locked_o` update one clock after the qualifying strobe.
- Each coarse bit costs 1 write cycle + `SETTLE_CYCLES` + the `pd_valid_i` wait.
- With `pd_valid_i` held high, acquisition takes `RO_WIDTH*(SETTLE_CYCLES+2)` clocks from `start_i` to TRACK.
- Back-to-back `dco_cc_valid_i` (every cycle) is supported at full rate.
- `busy_o` rises the cycle after `start_i` and falls on entry to TRACK.

## Test plan
- **Reset:** assert `rst_i` mid-SETTLE → next cycle `f_sel_o`=0x80, `bias_o`=0x80, state 0, all flags 0.
- **Coarse search:** behavioural model `pd_fast = f_sel > 0x5A`, `pd_valid_i` always high → trials 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B; `bias_o`=0x5A; TRACK entered after 144 clocks.
- **Tracking update:** bias 0x5A, `dco_cc_i`=-3 valid → `f_sel_o`=0x57 next cycle, upd pulse, `sat_o`=0.
- **Saturation and re-acquisition:**
  - bias 0xF0, `dco_cc_i`=+0x7F → `f_sel_o`=0xFF, `sat_o`=1.
  - bias 0x10, `dco_cc_i`=-0x80 → `f_sel_o`=0x00, `sat_o`=1.
  - 16 consecutive saturated updates → state 1, `locked_o`=0.
- **Lock:**
  - 8 updates of +1 → `locked_o` rises after the 8th.
  - A following update of +3 → `locked_o` falls next cycle; 8 fresh in-threshold updates are needed to relock.
- **Restart:** `start_i` while locked in TRACK → state 1 next cycle, `f_sel_o`=0x80, `locked_o`=0, `bias_o` retains 0x5A until the search completes.
